// File: rtl/xor8bit_descrambler_if.sv
// Byte-link handshake bundle for the descrambler: seed control, input and output streams, counter.
// With PARITY_CHECK_EN defined the bundle also carries in_parity and par_err.
interface xor8bit_descrambler_if #(
  parameter int CNT_W = 16
);
  logic             seed_load;
  logic [7:0]       seed_in;
  logic             in_bypass;
  logic [7:0]       in_data;
  logic             in_valid;
  logic             in_ready;
  logic [7:0]       out_data;
  logic             out_valid;
  logic             out_ready;
  logic [CNT_W-1:0] byte_cnt;
`ifdef PARITY_CHECK_EN
  logic             in_parity;
  logic             par_err;

  modport slave (
    input  seed_load, seed_in, in_bypass, in_data, in_valid, out_ready, in_parity,
    output in_ready, out_data, out_valid, byte_cnt, par_err
  );
  modport master (
    output seed_load, seed_in, in_bypass, in_data, in_valid, out_ready, in_parity,
    input  in_ready, out_data, out_valid, byte_cnt, par_err
  );
`else
  modport slave (
    input  seed_load, seed_in, in_bypass, in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid, byte_cnt
  );
  modport master (
    output seed_load, seed_in, in_bypass, in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid, byte_cnt
  );
`endif
endinterface

// File: rtl/xor8bit_descrambler.sv
// Descrambler: XORs each accepted byte with an x^8+x^6+x^5+x^4+1 LFSR keystream, one output register.
// Optional macro PARITY_CHECK_EN adds a sticky even-parity check on the recovered byte.
module xor8bit_descrambler #(
  parameter int         CNT_W    = 16,
  parameter logic [7:0] SEED_DEF = 8'h01
) (
  input  logic                 clk,
  input  logic                 rst,
  xor8bit_descrambler_if.slave bus
);

  logic [7:0]       r_lfsr;
  logic [7:0]       r_out_data;
  logic             r_out_valid;
  logic [CNT_W-1:0] r_byte_cnt;

  logic             w_in_ready;
  logic             w_accept;
  logic [7:0]       w_out_byte;
  logic [7:0]       w_lfsr_adv;

  // Eight Fibonacci steps unrolled so the keystream advances a whole byte per accept.
  function automatic logic [7:0] lfsr_step8(input logic [7:0] s);
    logic [7:0] v;
    v = s;
    for (int k = 0; k < 8; k++) begin
      v = {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
    end
    return v;
  endfunction

  assign w_in_ready = !bus.seed_load && (!r_out_valid || bus.out_ready);
  assign w_accept   = bus.in_valid && w_in_ready;
  assign w_out_byte = bus.in_bypass ? bus.in_data : (bus.in_data ^ r_lfsr);
  assign w_lfsr_adv = lfsr_step8(r_lfsr);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_lfsr      <= SEED_DEF;
      r_out_data  <= 8'h00;
      r_out_valid <= 1'b0;
      r_byte_cnt  <= '0;
    end else if (bus.seed_load) begin
      // A zero seed would lock the LFSR at zero forever.
      r_lfsr      <= (bus.seed_in == 8'h00) ? 8'h01 : bus.seed_in;
      r_out_valid <= 1'b0;
    end else if (w_accept) begin
      r_out_data  <= w_out_byte;
      r_out_valid <= 1'b1;
      r_byte_cnt  <= r_byte_cnt + CNT_W'(1);
      if (!bus.in_bypass) begin
        r_lfsr <= w_lfsr_adv;
      end
    end else if (bus.out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_data  = r_out_data;
  assign bus.out_valid = r_out_valid;
  assign bus.byte_cnt  = r_byte_cnt;

`ifdef PARITY_CHECK_EN
  logic r_par_err;

  always_ff @(posedge clk) begin
    if (rst || bus.seed_load) begin
      r_par_err <= 1'b0;
    end else if (w_accept && ((^w_out_byte) != bus.in_parity)) begin
      r_par_err <= 1'b1;
    end
  end

  assign bus.par_err = r_par_err;
`endif

endmodule
